// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM stage: load/store to dbus requests, load align/extend, writeback bundle
module mem_access_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [1:0]      ex_msize,
    input  logic            ex_zero_ext,
    input  logic [4:0]      ex_dst,
    input  logic            ex_reg_write,
    output logic            dreq_valid,
    output logic [XLEN-1:0] dreq_addr,
    output logic [1:0]      dreq_size,
    output logic [7:0]      dreq_strobe,
    output logic [XLEN-1:0] dreq_data,
    input  logic            dresp_addr_ok,
    input  logic            dresp_data_ok,
    input  logic [XLEN-1:0] dresp_data,
    output logic            stall_mem,
    output logic            mem_misalign,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_pc,
    output logic [XLEN-1:0] wb_result,
    output logic [4:0]      wb_dst,
    output logic            wb_reg_write
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ADDR = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;

    logic [2:0]        addr_off;
    logic              addr_bad;
    logic              is_mem;
    logic              memop;
    logic              req;
    logic              stall;
    logic [7:0]        size_mask;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   load_val;

    assign addr_off = ex_alu_result[2:0];
    assign is_mem   = ex_valid & (ex_mem_read | ex_mem_write);

    always_comb begin
        addr_bad  = 1'b0;
        size_mask = 8'h01;
        case (ex_msize)
            2'd0: begin addr_bad = 1'b0;           size_mask = 8'h01; end
            2'd1: begin addr_bad = addr_off[0];    size_mask = 8'h03; end
            2'd2: begin addr_bad = |addr_off[1:0]; size_mask = 8'h0F; end
            default: begin addr_bad = |addr_off;   size_mask = 8'hFF; end
        endcase
    end

    assign memop = is_mem & ~addr_bad;

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        req     = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (memop) begin
                    req   = 1'b1;
                    stall = 1'b1;
                    if (dresp_addr_ok && dresp_data_ok) begin
                        state_d = DONE;
                        rdata_d = dresp_data;
                    end else if (dresp_addr_ok) begin
                        state_d = WAIT_DATA;
                    end else begin
                        state_d = WAIT_ADDR;
                    end
                end
            end
            WAIT_ADDR: begin
                req   = 1'b1;
                stall = 1'b1;
                if (dresp_addr_ok && dresp_data_ok) begin
                    state_d = DONE;
                    rdata_d = dresp_data;
                end else if (dresp_addr_ok) begin
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                stall = 1'b1;
                if (dresp_data_ok) begin
                    state_d = DONE;
                    rdata_d = dresp_data;
                end
            end
            default: begin
                // Upstream still holds the finished instruction for this one cycle.
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        shifted  = rdata_q >> {addr_off, 3'b000};
        load_val = shifted;
        case (ex_msize)
            2'd0: load_val = ex_zero_ext ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                         : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            2'd1: load_val = ex_zero_ext ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                         : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            2'd2: load_val = ex_zero_ext ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                         : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            default: load_val = shifted;
        endcase
    end

    assign dreq_valid   = req & ~reset;
    assign dreq_addr    = ex_alu_result;
    assign dreq_size    = ex_msize;
    assign dreq_strobe  = ex_mem_write ? (size_mask << addr_off) : 8'h00;
    assign dreq_data    = ex_store_data << {addr_off, 3'b000};

    assign stall_mem    = stall & ~reset;
    assign mem_misalign = is_mem & addr_bad & ~reset;

    assign wb_valid     = ex_valid & ~stall_mem & ~reset;
    assign wb_pc        = ex_pc;
    assign wb_dst       = ex_dst;
    assign wb_result    = (state_q == DONE && ex_mem_read) ? load_val : ex_alu_result;
    assign wb_reg_write = ex_reg_write & ~mem_misalign;

    // A data response may only arrive together with or after address acceptance.
    a_no_early_data: assert property (@(posedge clk) disable iff (reset)
        (state_q == WAIT_ADDR && dresp_data_ok) |-> dresp_addr_ok);

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit with latency-schedule model
`timescale 1ns/1ps
module tb_mem_access_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        ex_valid;
    logic [63:0] ex_pc, ex_alu_result, ex_store_data;
    logic        ex_mem_read, ex_mem_write;
    logic [1:0]  ex_msize;
    logic        ex_zero_ext;
    logic [4:0]  ex_dst;
    logic        ex_reg_write;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [63:0] dresp_data;
    logic        stall_mem, mem_misalign;
    logic        wb_valid;
    logic [63:0] wb_pc, wb_result;
    logic [4:0]  wb_dst;
    logic        wb_reg_write;

    mem_access_unit #(.XLEN(64)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_msize(ex_msize), .ex_zero_ext(ex_zero_ext), .ex_dst(ex_dst), .ex_reg_write(ex_reg_write),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .stall_mem(stall_mem), .mem_misalign(mem_misalign),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_result(wb_result), .wb_dst(wb_dst),
        .wb_reg_write(wb_reg_write)
    );

    int checks = 0;
    int errors = 0;

    logic        exp_en = 1'b0;
    logic        e_dreq, e_stall, e_wb, e_mis, e_store, e_regw, e_chk_res;
    logic [63:0] e_res, e_addr, e_data, e_pc;
    logic [1:0]  e_size;
    logic [7:0]  e_strb;
    logic [4:0]  e_dst;

    int          n_stall, n_dreq, n_wb;
    logic [63:0] cap_res, cap_data;
    logic [7:0]  cap_strb;
    logic        cap_regw;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] f_load(input logic [63:0] raw, input logic [2:0] off,
                                           input logic [1:0] sz, input logic z);
        int          nbits;
        logic [63:0] v, mask;
        nbits = 8 * (1 << sz);
        v = raw >> (8 * off);
        if (sz == 2'd3) return v;
        mask = (64'd1 << nbits) - 64'd1;
        v = v & mask;
        if (!z && v[nbits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [7:0] f_strb(input logic wr, input logic [2:0] off, input logic [1:0] sz);
        int m;
        if (!wr) return 8'h00;
        m = ((1 << (1 << sz)) - 1) << off;
        return 8'(m & 255);
    endfunction

    always @(negedge clk) begin
        if (exp_en) begin
            chk("dreq_valid", dreq_valid, e_dreq);
            chk("stall_mem", stall_mem, e_stall);
            chk("wb_valid", wb_valid, e_wb);
            chk("mem_misalign", mem_misalign, e_mis);
            if (e_dreq) begin
                chk("dreq_addr", dreq_addr, e_addr);
                chk("dreq_size", dreq_size, e_size);
                chk("dreq_strobe", dreq_strobe, e_strb);
                if (e_store) chk("dreq_data", dreq_data, e_data);
            end
            if (e_wb) begin
                chk("wb_pc", wb_pc, e_pc);
                chk("wb_dst", wb_dst, e_dst);
                chk("wb_reg_write", wb_reg_write, e_regw);
                if (e_chk_res) chk("wb_result", wb_result, e_res);
            end
            if (stall_mem) n_stall++;
            if (dreq_valid) begin
                n_dreq++;
                cap_strb = dreq_strobe;
                cap_data = dreq_data;
            end
            if (wb_valid) begin
                n_wb++;
                cap_res  = wb_result;
                cap_regw = wb_reg_write;
            end
        end
    end

    task automatic bus_idle();
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = {$urandom, $urandom};
    endtask

    task automatic expect_quiet();
        e_dreq = 1'b0; e_stall = 1'b0; e_wb = 1'b0; e_mis = 1'b0;
        e_store = 1'b0; e_regw = 1'b0; e_chk_res = 1'b0;
        exp_en = 1'b1;
    endtask

    // a: cycles from issue until addr_ok, d: cycles from addr_ok until data_ok
    task automatic run_op(input logic [63:0] pc, input logic [63:0] addr, input logic [63:0] sd,
                          input logic rd, input logic wr, input logic [1:0] sz, input logic z,
                          input logic [4:0] dst, input logic rw, input int a, input int d,
                          input logic [63:0] raw);
        logic mis, go;
        int   last;
        mis  = (rd | wr) && ((addr % (64'd1 << sz)) != 64'd0);
        go   = (rd | wr) && !mis;
        last = go ? (a + d + 1) : 0;
        n_stall = 0; n_dreq = 0; n_wb = 0;
        for (int k = 0; k <= last; k++) begin
            @(posedge clk); #1;
            ex_valid = 1'b1; ex_pc = pc; ex_alu_result = addr; ex_store_data = sd;
            ex_mem_read = rd; ex_mem_write = wr; ex_msize = sz; ex_zero_ext = z;
            ex_dst = dst; ex_reg_write = rw;
            if (go) begin
                dresp_addr_ok = (k == a);
                dresp_data_ok = (k == a + d);
                dresp_data    = (k == a + d) ? raw : {$urandom, $urandom};
                e_dreq  = (k <= a);
                e_stall = (k <= a + d);
                e_wb    = (k == last);
            end else begin
                bus_idle();
                e_dreq = 1'b0; e_stall = 1'b0; e_wb = 1'b1;
            end
            e_mis     = mis;
            e_store   = wr;
            e_addr    = addr;
            e_size    = sz;
            e_strb    = f_strb(wr, addr[2:0], sz);
            e_data    = sd << (8 * addr[2:0]);
            e_pc      = pc;
            e_dst     = dst;
            e_regw    = rw && !mis;
            e_chk_res = !mis;
            e_res     = (rd && !mis) ? f_load(raw, addr[2:0], sz, z) : addr;
            exp_en    = 1'b1;
        end
        @(negedge clk); #1;
    endtask

    task automatic bubble();
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0;
        bus_idle();
        expect_quiet();
    endtask

    initial begin
        logic [63:0] raw, addr;
        logic [1:0]  sz;
        int          t;

        reset = 1'b1;
        ex_valid = 1'b1; ex_pc = 64'h100; ex_alu_result = 64'h8000_0008; ex_store_data = '0;
        ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_msize = 2'd3; ex_zero_ext = 1'b0;
        ex_dst = 5'd1; ex_reg_write = 1'b1;
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'h55;

        // Outputs held quiet during reset, even with an aligned then a misaligned op presented.
        @(posedge clk); #1; expect_quiet();
        @(posedge clk); #1; ex_alu_result = 64'h8000_0003; expect_quiet();
        @(posedge clk); #1;
        @(negedge clk); #1;
        reset = 1'b0;
        bubble();

        run_op(64'h200, 64'h1234, 64'h0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd3, 1'b1, 0, 0, 64'h0);
        chk("t1_result", cap_res, 64'h1234);
        chk("t1_stall_cycles", n_stall, 0);

        run_op(64'h204, 64'h8000_0003, 64'h0, 1'b1, 1'b0, 2'd0, 1'b0, 5'd4, 1'b1, 0, 0, 64'h8000_0000);
        chk("t2_lb_result", cap_res, 64'hFFFF_FFFF_FFFF_FF80);
        chk("t2_stall_cycles", n_stall, 1);
        run_op(64'h208, 64'h8000_0003, 64'h0, 1'b1, 1'b0, 2'd0, 1'b1, 5'd4, 1'b1, 0, 0, 64'h8000_0000);
        chk("t2_lbu_result", cap_res, 64'h80);

        run_op(64'h20c, 64'h8000_0004, 64'h1122_3344, 1'b0, 1'b1, 2'd2, 1'b0, 5'd0, 1'b0, 1, 0, 64'h0);
        chk("t3_strobe", cap_strb, 8'hF0);
        chk("t3_data", cap_data, 64'h1122_3344_0000_0000);
        chk("t3_reg_write", cap_regw, 1'b0);

        run_op(64'h210, 64'h8000_0010, 64'h0, 1'b1, 1'b0, 2'd3, 1'b0, 5'd5, 1'b1, 3, 2,
               64'hDEAD_BEEF_CAFE_F00D);
        chk("t4_dreq_cycles", n_dreq, 4);
        chk("t4_stall_cycles", n_stall, 6);
        chk("t4_wb_count", n_wb, 1);
        chk("t4_result", cap_res, 64'hDEAD_BEEF_CAFE_F00D);

        run_op(64'h214, 64'h8000_0002, 64'h0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd6, 1'b1, 0, 0, 64'h0);
        chk("t5_dreq_cycles", n_dreq, 0);
        chk("t5_stall_cycles", n_stall, 0);
        chk("t5_reg_write", cap_regw, 1'b0);

        // Reset while waiting for data, then a late data_ok that must be ignored.
        n_wb = 0; n_dreq = 0;
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_pc = 64'h218; ex_alu_result = 64'h8000_0020; ex_mem_read = 1'b1;
        ex_mem_write = 1'b0; ex_msize = 2'd3; ex_dst = 5'd7; ex_reg_write = 1'b1;
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b0;
        e_dreq = 1'b1; e_stall = 1'b1; e_wb = 1'b0; e_mis = 1'b0; e_store = 1'b0;
        e_addr = 64'h8000_0020; e_size = 2'd3; e_strb = 8'h00;
        @(posedge clk); #1;
        reset = 1'b1; dresp_addr_ok = 1'b0;
        expect_quiet();
        @(posedge clk); #1;
        reset = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0; ex_reg_write = 1'b0;
        dresp_data_ok = 1'b1; dresp_data = 64'hBAD0_BAD0_BAD0_BAD0;
        expect_quiet();
        @(negedge clk); #1;
        chk("t6_no_wb", n_wb, 0);
        chk("t6_no_reissue", n_dreq, 1);
        run_op(64'h21c, 64'h8000_0006, 64'h0, 1'b1, 1'b0, 2'd1, 1'b0, 5'd8, 1'b1, 1, 1,
               64'h8001_0000_0000_0000);
        chk("t6_lh_result", cap_res, 64'hFFFF_FFFF_FFFF_8001);

        for (int i = 0; i < 200; i++) begin
            t    = $urandom_range(0, 2);
            sz   = 2'($urandom_range(0, 3));
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 4) != 0) addr = addr & ~((64'd1 << sz) - 64'd1);
            raw  = {$urandom, $urandom};
            run_op({$urandom, $urandom}, addr, {$urandom, $urandom},
                   (t == 1), (t == 2), sz, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), raw);
            if ($urandom_range(0, 3) == 0) bubble();
        end
        bubble();
        @(negedge clk); #1;
        exp_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
